dadd_fifo_adder: RTL and testbench
==================================

// Module: dadd_fifo_adder
// PURPOSE
//  Parametrised successor of the dadd data-add DUT.
//  - Accepts {addr, data} words on a valid/ready input port.
//  - Adds the constant ADD_VAL, with wrap or saturating arithmetic.
//  - Buffers results in a DEPTH-entry first-word-fall-through FIFO; output port has valid/ready backpressure.
//  - Keeps output-word and overflow statistics counters.
//  - Sits between the dadd master agent (mcb) and slave/monitor agents (scb/pcb) as the DUT.
// PARAMETERS
//  DATA_W   32  data width of dadd_in / dadd_out
//  ADDR_W   32  address width of dadd_in_addr / dadd_out_addr
//  ADD_VAL  1   constant added to each data word (DATA_W bits)
//  DEPTH    4   FIFO entries; power of 2, >= 2
//  SAT_EN   0   0: wrap on overflow; 1: saturate to all-ones
//  CNT_W    16  width of statistics counters
// PORTS
//  clk            in   1            single clock, all logic on posedge
//  reset          in   1            synchronous, active-high
//  dadd_in_en     in   1            input word valid
//  dadd_in_addr   in   ADDR_W       input address
//  dadd_in        in   DATA_W       input data
//  dadd_in_rdy    out  1            block can accept a word this cycle
//  dadd_out_en    out  1            output word valid (FIFO not empty)
//  dadd_out_addr  out  ADDR_W       address of head entry
//  dadd_out       out  DATA_W       result of head entry
//  dadd_out_ovf   out  1            head entry overflowed during the add
//  dadd_out_rdy   in   1            downstream accepts head entry
//  fill_cnt       out  clog2(DEPTH)+1  current FIFO occupancy
//  pkt_cnt        out  CNT_W        words popped; wraps max->0
//  ovf_cnt        out  CNT_W        overflowed words accepted; saturates at max
// BEHAVIOUR
//  Reset:
//  - clk and reset only; reset is synchronous, active-high.
//  - Reset sampled high at a posedge empties the FIFO (pointers = 0) and clears counters.
//  - All outputs are 0 in the following cycle, including in_rdy, out_en, out, out_addr, out_ovf, fill_cnt, pkt_cnt and ovf_cnt.
//  - in_rdy is also 0 while reset is high; dadd_in_en is ignored while reset is high.
//  Transfers:
//  - push = in_en & in_rdy; pop = out_en & out_rdy.
//  - A transfer happens at the posedge where both signals are high.
//  Flow control:
//  - in_rdy = (fill_cnt < DEPTH), registered-state only; no combinational path from out_rdy to in_rdy.
//  - out_en = (fill_cnt != 0). The head entry is driven directly from the FIFO (FWFT).
//  Arithmetic:
//  - sum = {1'b0,dadd_in} + ADD_VAL, computed in DATA_W+1 bits; ovf = sum[DATA_W].
//  - SAT_EN=0: stored data = sum[DATA_W-1:0]. SAT_EN=1: stored data = ovf ? all-ones : sum[DATA_W-1:0].
//  - dadd_out_addr = dadd_in_addr unchanged. Entry stored = {addr, data, ovf}.
//  Latency: a word pushed at edge N is visible on the out_* ports in cycle N+1 (after edge N) if the FIFO was empty.
//  Ordering: strict FIFO order; no reordering or drop.
//  Simultaneous push and pop: allowed whenever in_rdy=1; fill_cnt is unchanged; both pointers advance.
//  Full: in_rdy=0. A pop at full does not allow a same-cycle push; in_rdy rises the cycle after.
//  Empty: out_en=0, out data/addr/ovf hold the last popped values; out_rdy is ignored.
//  Pointers: wr_ptr/rd_ptr are clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//  Counters:
//  - pkt_cnt += 1 on each pop, wrapping.
//  - ovf_cnt += 1 on each push with ovf=1, holding at all-ones.
//  Reset mid-operation: all stored entries are discarded; no partial output is ever presented.
// TESTING
//  1 Reset release, push addr=0x100 data=0x10, out_rdy=1 -> next cycle out_en=1, out=0x11, out_addr=0x100, ovf=0; pkt_cnt=1 after pop.
//  2 SAT_EN=0, push 0xFFFFFFFF -> out=0x00000000, ovf=1, ovf_cnt=1. SAT_EN=1, same push -> out=0xFFFFFFFF, ovf=1.
//  3 out_rdy=0, DEPTH=4, 5 pushes offered -> 4 accepted, in_rdy=0, fill_cnt=4. Then out_rdy=1 -> 4 words drain in order, in_rdy=1 one cycle after the first pop.
//  4 fill_cnt=2, push and pop in the same cycle -> fill_cnt stays 2, head advances, new word lands at tail.
//  5 3 entries queued, reset high for 1 cycle -> next cycle out_en=0, fill_cnt=0, pkt_cnt=0, ovf_cnt=0, in_rdy=0; in_rdy=1 after reset drops.
//  6 Stream 8 words 0..7, in_en=1, out_rdy=1 continuously -> outputs 1..8 on consecutive cycles, no bubbles, pkt_cnt=8, pointers wrap cleanly.

Source files
------------

// File: rtl/dadd_fifo_adder_if.sv
// Valid/ready bus for the dadd block: {addr, data} words go in, and results with an overflow flag come out.
// The master drives words in and accepts results; the slave is the adder.
interface dadd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              dadd_in_en;
  logic [ADDR_W-1:0] dadd_in_addr;
  logic [DATA_W-1:0] dadd_in;
  logic              dadd_in_rdy;
  logic              dadd_out_en;
  logic [ADDR_W-1:0] dadd_out_addr;
  logic [DATA_W-1:0] dadd_out;
  logic              dadd_out_ovf;
  logic              dadd_out_rdy;

  modport master (
    output dadd_in_en, dadd_in_addr, dadd_in, dadd_out_rdy,
    input  dadd_in_rdy, dadd_out_en, dadd_out_addr, dadd_out, dadd_out_ovf
  );

  modport slave (
    input  dadd_in_en, dadd_in_addr, dadd_in, dadd_out_rdy,
    output dadd_in_rdy, dadd_out_en, dadd_out_addr, dadd_out, dadd_out_ovf
  );
endinterface

// File: rtl/dadd_fifo_adder.sv
// Adds ADD_VAL to each incoming {addr, data} word, with wrap or saturate on overflow.
// Results are queued in a first-word-fall-through FIFO, and the block counts pops and overflows.
module dadd_fifo_adder #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 32,
  parameter logic [DATA_W-1:0] ADD_VAL = DATA_W'(1),
  parameter int                DEPTH   = 4,
  parameter bit                SAT_EN  = 1'b0,
  parameter int                CNT_W   = 16,
  localparam int               PTR_W   = $clog2(DEPTH),
  localparam int               FILL_W  = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  dadd_if.slave             bus,
  output logic [FILL_W-1:0] o_fill_cnt,
  output logic [CNT_W-1:0]  o_pkt_cnt,
  output logic [CNT_W-1:0]  o_ovf_cnt
);
  localparam int ENTRY_W = ADDR_W + DATA_W + 1;

  logic [DATA_W:0]    w_sum;
  logic               w_ovf;
  logic [DATA_W-1:0]  w_data;
  logic               w_in_rdy;
  logic               w_out_en;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [ENTRY_W-1:0] r_last;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [FILL_W-1:0]  r_fill;
  logic               r_rst_blk;
  logic [CNT_W-1:0]   r_pkt_cnt;
  logic [CNT_W-1:0]   r_ovf_cnt;

  assign w_sum  = {1'b0, bus.dadd_in} + {1'b0, ADD_VAL};
  assign w_ovf  = w_sum[DATA_W];
  assign w_data = (SAT_EN && w_ovf) ? '1 : w_sum[DATA_W-1:0];

  // r_rst_blk keeps in_rdy low for the first cycle after reset so that every output reads as zero.
  assign w_in_rdy = !i_reset && !r_rst_blk && (r_fill < FILL_W'(DEPTH));
  assign w_out_en = (r_fill != '0);
  assign w_push   = bus.dadd_in_en && w_in_rdy;
  assign w_pop    = w_out_en && bus.dadd_out_rdy;

  // When empty, present the last popped entry, not stale RAM contents.
  assign w_head = w_out_en ? r_mem[r_rd_ptr] : r_last;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.dadd_in_addr, w_data, w_ovf};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_fill    <= '0;
      r_last    <= '0;
      r_rst_blk <= 1'b1;
      r_pkt_cnt <= '0;
      r_ovf_cnt <= '0;
    end else begin
      r_rst_blk <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_last    <= r_mem[r_rd_ptr];
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
      if (w_push && !w_pop)      r_fill <= r_fill + FILL_W'(1);
      else if (!w_push && w_pop) r_fill <= r_fill - FILL_W'(1);
      if (w_push && w_ovf && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
    end
  end

  assign bus.dadd_in_rdy = w_in_rdy;
  assign bus.dadd_out_en = w_out_en;
  assign {bus.dadd_out_addr, bus.dadd_out, bus.dadd_out_ovf} = w_head;
  assign o_fill_cnt = r_fill;
  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_ovf_cnt  = r_ovf_cnt;
endmodule

// File: tb/tb_dadd_fifo_adder.sv
// Testbench for dadd_fifo_adder: runs a wrap instance and a saturate instance on the same stimulus.
// Directed scenarios are followed by a random phase that is compared against a queue-based model.
module tb_dadd_fifo_adder;
  localparam int DW = 32, AW = 32, DEPTH = 4, CW = 4, FW = 3;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {logic [31:0] addr; logic [31:0] data;} ent_t;
  typedef logic [1+1+AW+DW+1+FW+CW+CW-1:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_en = 1'b0, out_rdy = 1'b0;
  logic [31:0] in_addr = '0, in_data = '0;
  logic [FW-1:0] fill_w, fill_s;
  logic [CW-1:0] pkt_w, pkt_s, ovfc_w, ovfc_s;
  int errors = 0, checks = 0;

  dadd_if #(.DATA_W(DW), .ADDR_W(AW)) ifw ();
  dadd_if #(.DATA_W(DW), .ADDR_W(AW)) ifs ();

  assign ifw.dadd_in_en = in_en;   assign ifs.dadd_in_en = in_en;
  assign ifw.dadd_in_addr = in_addr; assign ifs.dadd_in_addr = in_addr;
  assign ifw.dadd_in = in_data;    assign ifs.dadd_in = in_data;
  assign ifw.dadd_out_rdy = out_rdy; assign ifs.dadd_out_rdy = out_rdy;

  dadd_fifo_adder #(.DATA_W(DW), .ADDR_W(AW), .ADD_VAL(32'd1), .DEPTH(DEPTH), .SAT_EN(1'b0), .CNT_W(CW))
    dut_w (.i_clk(clk), .i_reset(rst), .bus(ifw), .o_fill_cnt(fill_w), .o_pkt_cnt(pkt_w), .o_ovf_cnt(ovfc_w));
  dadd_fifo_adder #(.DATA_W(DW), .ADDR_W(AW), .ADD_VAL(32'd1), .DEPTH(DEPTH), .SAT_EN(1'b1), .CNT_W(CW))
    dut_s (.i_clk(clk), .i_reset(rst), .bus(ifs), .o_fill_cnt(fill_s), .o_pkt_cnt(pkt_s), .o_ovf_cnt(ovfc_s));

  vec_t obs_w, obs_s;
  assign obs_w = {ifw.dadd_in_rdy, ifw.dadd_out_en, ifw.dadd_out_addr, ifw.dadd_out, ifw.dadd_out_ovf, fill_w, pkt_w, ovfc_w};
  assign obs_s = {ifs.dadd_in_rdy, ifs.dadd_out_en, ifs.dadd_out_addr, ifs.dadd_out, ifs.dadd_out_ovf, fill_s, pkt_s, ovfc_s};

  // Reference model: a queue of accepted raw words, with results derived from plain 64-bit arithmetic.
  ent_t m_q[$];
  ent_t m_last;
  bit   m_last_v = 1'b0, m_blk = 1'b1;
  int   m_pkt = 0, m_ovfc = 0;

  function automatic bit ovf_of(logic [31:0] d);
    logic [63:0] s;
    s = {32'd0, d} + 64'd1;
    return s > 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] res_of(logic [31:0] d, bit sat);
    logic [63:0] s;
    s = {32'd0, d} + 64'd1;
    if (s > 64'hFFFF_FFFF) return sat ? 32'hFFFF_FFFF : 32'(s - 64'h1_0000_0000);
    return s[31:0];
  endfunction

  function automatic vec_t exp_vec(bit sat);
    bit rdy, en, o;
    logic [31:0] a, d;
    rdy = !rst && !m_blk && (m_q.size() < DEPTH);
    en  = (m_q.size() != 0);
    a = '0; d = '0; o = 1'b0;
    if (en) begin
      a = m_q[0].addr; d = res_of(m_q[0].data, sat); o = ovf_of(m_q[0].data);
    end else if (m_last_v) begin
      a = m_last.addr; d = res_of(m_last.data, sat); o = ovf_of(m_last.data);
    end
    return {rdy, en, a, d, o, FW'(m_q.size()), CW'(m_pkt), CW'(m_ovfc)};
  endfunction

  always @(posedge clk) begin : model
    bit push, pop;
    if (rst) begin
      m_q.delete(); m_blk = 1'b1; m_last_v = 1'b0; m_pkt = 0; m_ovfc = 0;
    end else begin
      push = in_en && !m_blk && (m_q.size() < DEPTH);
      pop  = (m_q.size() != 0) && out_rdy;
      if (pop) begin
        m_last = m_q.pop_front(); m_last_v = 1'b1; m_pkt = (m_pkt + 1) % (CMAX + 1);
      end
      if (push) begin
        m_q.push_back('{in_addr, in_data});
        if (ovf_of(in_data) && m_ovfc < CMAX) m_ovfc++;
      end
      m_blk = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_en = 1'b1; in_data = 32'h55; out_rdy = 1'b1;
    cyc(); cyc();
    checks++; if (obs_w !== '0) begin errors++; $display("FAIL reset_w: got %h want 0", obs_w); end
    checks++; if (obs_s !== '0) begin errors++; $display("FAIL reset_s: got %h want 0", obs_s); end
    rst = 1'b0; in_en = 1'b0; #1;
    checks++; if (ifw.dadd_in_rdy !== 1'b0) begin errors++; $display("FAIL rdy_after_rst: got %b want 0", ifw.dadd_in_rdy); end
    cyc();
    checks++; if ({ifw.dadd_in_rdy, ifs.dadd_in_rdy} !== 2'b11) begin errors++; $display("FAIL rdy_rise: got %b want 11", {ifw.dadd_in_rdy, ifs.dadd_in_rdy}); end
  endtask

  task automatic test_basic();
    in_en = 1'b1; in_addr = 32'h100; in_data = 32'h10; out_rdy = 1'b1;
    cyc(); in_en = 1'b0;
    checks++; if ({ifw.dadd_out_en, ifw.dadd_out_addr, ifw.dadd_out, ifw.dadd_out_ovf} !== {1'b1, 32'h100, 32'h11, 1'b0})
      begin errors++; $display("FAIL basic_head: got %b %h %h %b want 1 100 11 0", ifw.dadd_out_en, ifw.dadd_out_addr, ifw.dadd_out, ifw.dadd_out_ovf); end
    cyc();
    checks++; if ({pkt_w, ifw.dadd_out_en, ifw.dadd_out} !== {4'd1, 1'b0, 32'h11})
      begin errors++; $display("FAIL basic_pop: got pkt=%0d en=%b out=%h want 1 0 11", pkt_w, ifw.dadd_out_en, ifw.dadd_out); end
  endtask

  task automatic test_overflow();
    out_rdy = 1'b0; in_en = 1'b1; in_addr = 32'h200; in_data = 32'hFFFF_FFFF;
    cyc(); in_en = 1'b0;
    checks++; if ({ifw.dadd_out, ifw.dadd_out_ovf, ovfc_w} !== {32'h0, 1'b1, 4'd1})
      begin errors++; $display("FAIL ovf_wrap: got %h %b %0d want 0 1 1", ifw.dadd_out, ifw.dadd_out_ovf, ovfc_w); end
    checks++; if ({ifs.dadd_out, ifs.dadd_out_ovf, ovfc_s} !== {32'hFFFF_FFFF, 1'b1, 4'd1})
      begin errors++; $display("FAIL ovf_sat: got %h %b %0d want ffffffff 1 1", ifs.dadd_out, ifs.dadd_out_ovf, ovfc_s); end
    out_rdy = 1'b1;
    cyc();
    checks++; if ({ifs.dadd_out_en, ifs.dadd_out, pkt_s} !== {1'b0, 32'hFFFF_FFFF, 4'd2})
      begin errors++; $display("FAIL ovf_hold: got %b %h %0d want 0 ffffffff 2", ifs.dadd_out_en, ifs.dadd_out, pkt_s); end
  endtask

  task automatic test_full();
    out_rdy = 1'b0; in_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_addr = 32'h300 + 32'(i); in_data = 32'h20 + 32'(i);
      cyc();
    end
    checks++; if ({fill_w, ifw.dadd_in_rdy, ifs.dadd_in_rdy, ifw.dadd_out} !== {3'd4, 1'b0, 1'b0, 32'h21})
      begin errors++; $display("FAIL full: got fill=%0d rdy=%b%b head=%h want 4 00 21", fill_w, ifw.dadd_in_rdy, ifs.dadd_in_rdy, ifw.dadd_out); end
    out_rdy = 1'b1;
    cyc(); in_en = 1'b0;
    checks++; if ({fill_w, ifw.dadd_in_rdy, ifw.dadd_out} !== {3'd3, 1'b1, 32'h22})
      begin errors++; $display("FAIL full_pop: got fill=%0d rdy=%b head=%h want 3 1 22", fill_w, ifw.dadd_in_rdy, ifw.dadd_out); end
    for (int i = 1; i < 4; i++) begin
      checks++; if ({ifw.dadd_out_addr, ifw.dadd_out} !== {32'h300 + 32'(i), 32'h21 + 32'(i)})
        begin errors++; $display("FAIL drain_order: got %h %h want %h %h", ifw.dadd_out_addr, ifw.dadd_out, 32'h300 + 32'(i), 32'h21 + 32'(i)); end
      cyc();
    end
    checks++; if ({fill_w, ifw.dadd_out_en, pkt_w} !== {3'd0, 1'b0, 4'd6})
      begin errors++; $display("FAIL drain_end: got fill=%0d en=%b pkt=%0d want 0 0 6", fill_w, ifw.dadd_out_en, pkt_w); end
  endtask

  task automatic test_simul();
    out_rdy = 1'b0; in_en = 1'b1;
    in_data = 32'h30; cyc();
    in_data = 32'h31; cyc();
    in_data = 32'h32; out_rdy = 1'b1;
    cyc(); in_en = 1'b0;
    checks++; if ({fill_w, ifw.dadd_out} !== {3'd2, 32'h32})
      begin errors++; $display("FAIL simul: got fill=%0d head=%h want 2 32", fill_w, ifw.dadd_out); end
    cyc();
    checks++; if ({fill_w, ifw.dadd_out} !== {3'd1, 32'h33})
      begin errors++; $display("FAIL simul_tail: got fill=%0d head=%h want 1 33", fill_w, ifw.dadd_out); end
    cyc();
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0; in_en = 1'b1;
    for (int i = 0; i < 3; i++) begin in_data = 32'h40 + 32'(i); cyc(); end
    in_en = 1'b0; rst = 1'b1;
    cyc();
    checks++; if (obs_w !== '0) begin errors++; $display("FAIL mid_reset_w: got %h want 0", obs_w); end
    checks++; if (obs_s !== '0) begin errors++; $display("FAIL mid_reset_s: got %h want 0", obs_s); end
    rst = 1'b0;
    cyc();
    checks++; if (ifw.dadd_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_reset_rdy: got %b want 1", ifw.dadd_in_rdy); end
  endtask

  task automatic test_stream();
    out_rdy = 1'b1; in_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_addr = 32'h500 + 32'(i); in_data = 32'(i);
      cyc();
      checks++; if ({ifw.dadd_out_en, ifw.dadd_out, fill_w} !== {1'b1, 32'(i + 1), 3'd1})
        begin errors++; $display("FAIL stream: got en=%b out=%h fill=%0d want 1 %h 1", ifw.dadd_out_en, ifw.dadd_out, fill_w, 32'(i + 1)); end
    end
    in_en = 1'b0;
    cyc();
    checks++; if ({pkt_w, fill_w} !== {4'd8, 3'd0})
      begin errors++; $display("FAIL stream_end: got pkt=%0d fill=%0d want 8 0", pkt_w, fill_w); end
  endtask

  task automatic test_ovf_sat();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    out_rdy = 1'b1; in_en = 1'b1; in_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 18; i++) cyc();
    in_en = 1'b0;
    cyc();
    checks++; if ({ovfc_w, ovfc_s, pkt_w} !== {4'd15, 4'd15, 4'd2})
      begin errors++; $display("FAIL ovf_cnt_sat: got ovf=%0d/%0d pkt=%0d want 15/15 2", ovfc_w, ovfc_s, pkt_w); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      checks++; if (obs_w !== exp_vec(1'b0)) begin errors++; $display("FAIL rand_w: cycle %0d got %h want %h", n, obs_w, exp_vec(1'b0)); end
      checks++; if (obs_s !== exp_vec(1'b1)) begin errors++; $display("FAIL rand_s: cycle %0d got %h want %h", n, obs_s, exp_vec(1'b1)); end
      rst     = ($urandom_range(0, 79) == 0);
      in_en   = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 2) == 0);
      in_addr = $urandom;
      case ($urandom_range(0, 3))
        0:       in_data = 32'hFFFF_FFFF;
        1:       in_data = 32'hFFFF_FFFE;
        default: in_data = $urandom;
      endcase
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full();
    test_simul();
    test_reset_mid();
    test_stream();
    test_ovf_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
